// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
// State encoding, RV32 funct3 decode, byte-lane mask constants.
package lsu_pkg;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [7:0] MASK_BYTE  = 8'h01;
    localparam logic [7:0] MASK_HALF  = 8'h03;
    localparam logic [7:0] MASK_WORD  = 8'h0F;
    localparam logic [7:0] MASK_LANES = 8'h0F;

    function automatic logic funct3_legal(input logic wen, input logic [2:0] funct3);
        if (wen) begin
            return funct3 inside {F3_SB, F3_SH, F3_SW};
        end
        return funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        return ((funct3[1:0] == SZ_HALF) && (off == 2'd3)) ||
               ((funct3[1:0] == SZ_WORD) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Handshake bundle for lsu_ctrl: EXU request, data-memory port, WBU result.
// The slave modport is the LSU side; master is the surrounding pipeline/memory.
interface lsu_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    modport slave (
        input  in_valid, in_wen, in_funct3, in_addr, in_wdata,
        input  mem_req_ready, mem_resp_valid, mem_rdata, out_ready,
        output in_ready, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output out_valid, out_rdata, out_err
    );

    modport master (
        output in_valid, in_wen, in_funct3, in_addr, in_wdata,
        output mem_req_ready, mem_resp_valid, mem_rdata, out_ready,
        input  in_ready, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  out_valid, out_rdata, out_err
    );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane datapath: store mask/data shift into the word, load shift and extend.
// Bytes shifted out past lane 3 are simply lost (zero-filled on loads).
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [7:0]  st_wmask_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] ld_word;

    always_comb begin
        st_wmask_o = MASK_WORD;
        case (st_size_i)
            SZ_BYTE: st_wmask_o = (MASK_BYTE << st_off_i) & MASK_LANES;
            SZ_HALF: st_wmask_o = (MASK_HALF << st_off_i) & MASK_LANES;
            default: st_wmask_o = MASK_WORD;
        endcase
        st_wdata_o = st_wdata_i << {st_off_i, 3'b000};

        ld_word   = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = ld_word;
        case (ld_funct3_i)
            F3_LB:   ld_data_o = {{24{ld_word[7]}}, ld_word[7:0]};
            F3_LH:   ld_data_o = {{16{ld_word[15]}}, ld_word[15:0]};
            F3_LBU:  ld_data_o = {24'h0, ld_word[7:0]};
            F3_LHU:  ld_data_o = {16'h0, ld_word[15:0]};
            default: ld_data_o = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller, single outstanding access, IDLE->REQ->WAIT->RESP.
// Define LSU_MISALIGN_EN to reject misaligned half/word accesses with out_err.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input logic       clk,
    input logic       rst,
    lsu_ctrl_if.slave bus
);

    lsu_state_e  state_q;
    logic        wen_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [7:0]  cnt_q;

    logic [7:0]  st_wmask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        reject;

`ifdef LSU_MISALIGN_EN
    assign reject = !funct3_legal(bus.in_wen, bus.in_funct3) ||
                    is_misaligned(bus.in_funct3, bus.in_addr[1:0]);
`else
    assign reject = !funct3_legal(bus.in_wen, bus.in_funct3);
`endif

    lsu_lane u_lane (
        .st_size_i   (bus.in_funct3[1:0]),
        .st_off_i    (bus.in_addr[1:0]),
        .st_wdata_i  (bus.in_wdata),
        .st_wmask_o  (st_wmask),
        .st_wdata_o  (st_wdata),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .ld_rdata_i  (bus.mem_rdata),
        .ld_data_o   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            wen_q             <= 1'b0;
            funct3_q          <= 3'b000;
            off_q             <= 2'b00;
            cnt_q             <= 8'd0;
            bus.in_ready      <= 1'b1;
            bus.mem_req_valid <= 1'b0;
            bus.mem_wen       <= 1'b0;
            bus.mem_addr      <= 32'h0;
            bus.mem_wdata     <= 32'h0;
            bus.mem_wmask     <= 8'h00;
            bus.out_valid     <= 1'b0;
            bus.out_rdata     <= 32'h0;
            bus.out_err       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        wen_q        <= bus.in_wen;
                        funct3_q     <= bus.in_funct3;
                        off_q        <= bus.in_addr[1:0];
                        if (reject) begin
                            // Rejected accesses never touch memory.
                            state_q       <= StResp;
                            bus.out_valid <= 1'b1;
                            bus.out_err   <= 1'b1;
                            bus.out_rdata <= 32'h0;
                        end else begin
                            state_q           <= StReq;
                            bus.mem_req_valid <= 1'b1;
                            bus.mem_wen       <= bus.in_wen;
                            bus.mem_addr      <= {bus.in_addr[31:2], 2'b00};
                            bus.mem_wdata     <= bus.in_wen ? st_wdata : 32'h0;
                            bus.mem_wmask     <= bus.in_wen ? st_wmask : 8'h00;
                        end
                    end
                end
                StReq: begin
                    if (bus.mem_req_ready) begin
                        state_q           <= StWait;
                        bus.mem_req_valid <= 1'b0;
                        cnt_q             <= 8'd0;
                    end
                end
                StWait: begin
                    // A response in the final allowed cycle still wins over the timeout.
                    if (bus.mem_resp_valid) begin
                        state_q       <= StResp;
                        bus.out_valid <= 1'b1;
                        bus.out_err   <= 1'b0;
                        bus.out_rdata <= wen_q ? 32'h0 : ld_data;
                    end else if (cnt_q == 8'(RESP_TIMEOUT - 1)) begin
                        state_q       <= StResp;
                        bus.out_valid <= 1'b1;
                        bus.out_err   <= 1'b1;
                        bus.out_rdata <= 32'h0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StResp: begin
                    if (bus.out_ready) begin
                        state_q       <= StIdle;
                        bus.out_valid <= 1'b0;
                        bus.out_err   <= 1'b0;
                        bus.out_rdata <= 32'h0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// checked against a byte-level reference model. Honours LSU_MISALIGN_EN.
module tb_lsu_ctrl;

    localparam int unsigned TMO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.RESP_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          err;
        bit          access;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        bit          accepted;
        logic        busy_ready;
        bit          hung;
        int          req_hs;
        bit          req_unstable;
        logic [31:0] req_addr;
        logic        req_wen;
        logic [31:0] req_wdata;
        logic [7:0]  req_mask;
        int          n_wait;
        int          lat;
        logic [31:0] out_rdata;
        logic        out_err;
        bit          out_unstable;
        bit          idle_after;
    } obs_t;

    obs_t obs;

    // Reference: assemble bytes individually, extend by hand.
    function automatic exp_t model(input bit wen, input bit [2:0] f3, input bit [31:0] addr,
                                   input bit [31:0] wdata, input bit [31:0] rdata);
        exp_t     e;
        int       off;
        int       n;
        bit       legal;
        bit [31:0] v;
        off   = int'(addr[1:0]);
        n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.err = !legal;
`ifdef LSU_MISALIGN_EN
        if ((n == 2 && off == 3) || (n == 4 && off != 0)) e.err = 1'b1;
`endif
        e.access = !e.err;
        e.addr   = {addr[31:2], 2'b00};
        e.mask   = 8'h00;
        e.wdata  = 32'h0;
        e.rdata  = 32'h0;
        v        = 32'h0;
        if (e.access && wen) begin
            if (n == 4) e.mask = 8'h0F;
            else for (int i = 0; i < n; i++) if (off + i < 4) e.mask[off + i] = 1'b1;
            e.wdata = wdata << (8 * off);
        end else if (e.access) begin
            for (int i = 0; i < n; i++) if (off + i < 4) v[8*i +: 8] = rdata[8*(off+i) +: 8];
            if (!f3[2] && n < 4 && v[8*n-1]) for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
            e.rdata = v;
        end
        return e;
    endfunction

    task automatic clear_inputs();
        bus.in_valid       = 1'b0;
        bus.in_wen         = 1'b0;
        bus.in_funct3      = 3'b000;
        bus.in_addr        = 32'h0;
        bus.in_wdata       = 32'h0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 32'h0;
        bus.out_ready      = 1'b0;
    endtask

    // Called just after a negedge; returns just after a negedge with inputs idle.
    // resp_delay < 0 means memory never answers.
    task automatic run_txn(input bit wen, input bit [2:0] f3, input bit [31:0] addr,
                           input bit [31:0] wdata, input bit [31:0] rdata,
                           input int req_stall, input int resp_delay, input int out_stall);
        int n_stall = 0;
        int n_out   = 0;
        bit req_done = 0, resp_given = 0, done = 0, req_seen = 0, out_seen = 0;
        obs = '{default: 0};
        bus.in_valid  = 1'b1;
        bus.in_wen    = wen;
        bus.in_funct3 = f3;
        bus.in_addr   = addr;
        bus.in_wdata  = wdata;
        obs.accepted  = (bus.in_ready === 1'b1);
        @(posedge clk);
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            bus.in_valid       = 1'b0;
            bus.in_wdata       = $urandom;
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.out_ready      = 1'b0;
            bus.mem_rdata      = $urandom;
            if (c == 0) obs.busy_ready = bus.in_ready;
            if (bus.mem_req_valid === 1'b1) begin
                if (!req_seen) begin
                    req_seen      = 1;
                    obs.req_addr  = bus.mem_addr;
                    obs.req_wen   = bus.mem_wen;
                    obs.req_wdata = bus.mem_wdata;
                    obs.req_mask  = bus.mem_wmask;
                end else if (bus.mem_addr !== obs.req_addr || bus.mem_wen !== obs.req_wen ||
                             bus.mem_wdata !== obs.req_wdata || bus.mem_wmask !== obs.req_mask)
                    obs.req_unstable = 1;
                if (req_done) obs.req_unstable = 1;
                else if (n_stall == req_stall) begin
                    bus.mem_req_ready = 1'b1;
                    req_done          = 1;
                    obs.req_hs++;
                end else begin
                    n_stall++;
                    bus.mem_resp_valid = 1'($urandom_range(0, 1));
                end
            end else if (req_done && !resp_given && bus.out_valid !== 1'b1) begin
                if (resp_delay >= 0 && obs.n_wait == resp_delay) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = rdata;
                    resp_given         = 1;
                end
                obs.n_wait++;
            end
            if (bus.out_valid === 1'b1) begin
                if (!out_seen) begin
                    out_seen      = 1;
                    obs.lat       = c + 1;
                    obs.out_rdata = bus.out_rdata;
                    obs.out_err   = bus.out_err;
                end else if (bus.out_rdata !== obs.out_rdata || bus.out_err !== obs.out_err)
                    obs.out_unstable = 1;
                if (n_out == out_stall) begin
                    bus.out_ready = 1'b1;
                    done          = 1;
                end else begin
                    n_out++;
                    bus.mem_resp_valid = 1'($urandom_range(0, 1));
                end
            end
            @(posedge clk);
        end
        obs.hung = !done;
        @(negedge clk);
        clear_inputs();
        obs.idle_after = (bus.in_ready === 1'b1) && (bus.out_valid === 1'b0) &&
                         (bus.mem_req_valid === 1'b0);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.mem_req_valid !== 1'b0) begin n_err++;
            $display("FAIL rst_mem_req_valid: got %b want 0", bus.mem_req_valid); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++;
            $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        n_vec++; if ({bus.out_rdata, bus.out_err, bus.mem_wmask, bus.mem_addr} !== 73'h0)
            begin n_err++; $display("FAIL rst_outputs: got %h want 0",
                {bus.out_rdata, bus.out_err, bus.mem_wmask, bus.mem_addr}); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL idle_in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_load_byte();
        run_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        n_vec++; if (obs.req_addr !== 32'h8000_0000) begin n_err++;
            $display("FAIL lb_addr: got %h want 80000000", obs.req_addr); end
        n_vec++; if (obs.out_rdata !== 32'hFFFF_FF80) begin n_err++;
            $display("FAIL lb_rdata: got %h want ffffff80", obs.out_rdata); end
        n_vec++; if (obs.lat !== 3) begin n_err++;
            $display("FAIL lb_latency: got %0d want 3", obs.lat); end
        n_vec++; if (obs.req_wen !== 1'b0) begin n_err++;
            $display("FAIL lb_wen: got %b want 0", obs.req_wen); end
    endtask

    task automatic test_store_half();
        run_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 0, 1, 0);
        n_vec++; if (obs.req_mask !== 8'h0C) begin n_err++;
            $display("FAIL sh_mask: got %h want 0c", obs.req_mask); end
        n_vec++; if (obs.req_wdata !== 32'hABCD_0000) begin n_err++;
            $display("FAIL sh_wdata: got %h want abcd0000", obs.req_wdata); end
        n_vec++; if (obs.req_wen !== 1'b1) begin n_err++;
            $display("FAIL sh_wen: got %b want 1", obs.req_wen); end
        n_vec++; if ({obs.out_err, obs.out_rdata} !== 33'h0) begin n_err++;
            $display("FAIL sh_result: got %h want 0", {obs.out_err, obs.out_rdata}); end
    endtask

    task automatic test_stalls();
        run_txn(1'b1, 3'b010, 32'h8000_0010, 32'h1357_9BDF, 32'h0, 4, 2, 3);
        n_vec++; if (obs.req_unstable !== 1'b0 || obs.req_hs !== 1) begin n_err++;
            $display("FAIL stall_req: got unstable=%b hs=%0d want 0/1", obs.req_unstable,
                     obs.req_hs); end
        n_vec++; if (obs.out_unstable !== 1'b0) begin n_err++;
            $display("FAIL stall_out_stable: got %b want 0", obs.out_unstable); end
        n_vec++; if (obs.lat !== 9) begin n_err++;
            $display("FAIL stall_latency: got %0d want 9", obs.lat); end
        n_vec++; if (obs.idle_after !== 1'b1) begin n_err++;
            $display("FAIL stall_no_dup: got %b want 1", obs.idle_after); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'hDEAD_BEEF, 0, -1, 1);
        n_vec++; if (obs.n_wait !== TMO) begin n_err++;
            $display("FAIL tmo_wait_cycles: got %0d want %0d", obs.n_wait, TMO); end
        n_vec++; if (obs.out_err !== 1'b1 || obs.out_rdata !== 32'h0) begin n_err++;
            $display("FAIL tmo_result: got err=%b rdata=%h want 1/0", obs.out_err,
                     obs.out_rdata); end
        // Answer in the last allowed cycle must still count as a response.
        run_txn(1'b0, 3'b010, 32'h8000_0024, 32'h0, 32'h0BAD_CAFE, 0, TMO - 1, 0);
        n_vec++; if (obs.out_err !== 1'b0 || obs.out_rdata !== 32'h0BAD_CAFE) begin n_err++;
            $display("FAIL tmo_edge: got err=%b rdata=%h want 0/0badcafe", obs.out_err,
                     obs.out_rdata); end
    endtask

    task automatic test_misalign();
        int exp_hs;
        logic [31:0] exp_rd;
`ifdef LSU_MISALIGN_EN
        exp_hs = 0; exp_rd = 32'h0;
`else
        exp_hs = 1; exp_rd = 32'h0000_7788;
`endif
        run_txn(1'b0, 3'b010, 32'h8000_0102, 32'h0, 32'h7788_1122, 0, 0, 0);
        n_vec++; if (obs.req_hs !== exp_hs) begin n_err++;
            $display("FAIL misalign_access: got %0d want %0d", obs.req_hs, exp_hs); end
        n_vec++; if (obs.out_err !== 1'(1 - exp_hs) || obs.out_rdata !== exp_rd) begin n_err++;
            $display("FAIL misalign_result: got err=%b rdata=%h want %0d/%h", obs.out_err,
                     obs.out_rdata, 1 - exp_hs, exp_rd); end
    endtask

    task automatic test_illegal();
        run_txn(1'b0, 3'b110, 32'h8000_0000, 32'h0, 32'h1234_5678, 0, 0, 2);
        n_vec++; if (obs.req_hs !== 0 || obs.out_err !== 1'b1 || obs.lat !== 1) begin n_err++;
            $display("FAIL illegal_load: got hs=%0d err=%b lat=%0d want 0/1/1", obs.req_hs,
                     obs.out_err, obs.lat); end
        run_txn(1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 0, 0);
        n_vec++; if (obs.req_hs !== 0 || obs.out_err !== 1'b1) begin n_err++;
            $display("FAIL illegal_store: got hs=%0d err=%b want 0/1", obs.req_hs,
                     obs.out_err); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 3'b000, 32'h8000_0041, 32'h0000_00A5, 32'h0, 0, 0, 0);
        run_txn(1'b0, 3'b100, 32'h8000_0041, 32'h0, 32'h0000_A500, 0, 0, 0);
        n_vec++; if (obs.accepted !== 1'b1 || obs.out_rdata !== 32'h0000_00A5) begin n_err++;
            $display("FAIL b2b_second: got acc=%b rdata=%h want 1/000000a5", obs.accepted,
                     obs.out_rdata); end
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1; bus.in_wen = 1'b0; bus.in_funct3 = 3'b010;
        bus.in_addr = 32'h8000_0080;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        n_vec++; if (bus.mem_req_valid !== 1'b1) begin n_err++;
            $display("FAIL rstmid_req_up: got %b want 1", bus.mem_req_valid); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_vec++; if (bus.mem_req_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL rstmid_req_drop: got req=%b rdy=%b want 0/1", bus.mem_req_valid,
                     bus.in_ready); end
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0; bus.mem_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.mem_req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
                         bus.mem_req_valid !== 1'b0) begin n_err++;
                $display("FAIL rstmid_stray_resp: got ov=%b rdy=%b req=%b want 0/1/0",
                         bus.out_valid, bus.in_ready, bus.mem_req_valid); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit        wen, tmo;
        bit [2:0]  f3;
        bit [31:0] addr, wdata, rdata;
        int        rs, rd, os, exp_lat;
        exp_t      e;
        for (int t = 0; t < 150; t++) begin
            wen   = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                if (wen) f3 = 3'($urandom_range(0, 2));
                else     f3 = (f3 > 3'd5) ? 3'd2 : ((f3 == 3'd3) ? 3'd4 : f3);
            end
            addr  = $urandom; wdata = $urandom; rdata = $urandom;
            rs    = $urandom_range(0, 3);
            os    = $urandom_range(0, 3);
            tmo   = ($urandom_range(0, 9) == 0);
            rd    = tmo ? -1 : int'($urandom_range(0, TMO - 1));
            e     = model(wen, f3, addr, wdata, rdata);
            exp_lat = !e.access ? 1 : 3 + rs + (tmo ? int'(TMO) - 1 : rd);
            run_txn(wen, f3, addr, wdata, rdata, rs, rd, os);
            n_vec++; if (obs.hung || !obs.accepted || obs.busy_ready !== 1'b0) begin n_err++;
                $display("FAIL rnd_handshake[%0d]: got hung=%b acc=%b rdy=%b want 0/1/0", t,
                         obs.hung, obs.accepted, obs.busy_ready); end
            n_vec++; if (obs.req_hs !== int'(e.access)) begin n_err++;
                $display("FAIL rnd_access[%0d]: got %0d want %0d", t, obs.req_hs, e.access); end
            if (e.access) begin
                n_vec++; if (obs.req_addr !== e.addr || obs.req_wen !== wen ||
                             obs.req_wdata !== e.wdata || obs.req_mask !== e.mask) begin
                    n_err++;
                    $display("FAIL rnd_req[%0d]: got %h/%b/%h/%h want %h/%b/%h/%h", t,
                             obs.req_addr, obs.req_wen, obs.req_wdata, obs.req_mask,
                             e.addr, wen, e.wdata, e.mask); end
            end
            n_vec++; if (obs.out_err !== (e.err | tmo) ||
                         obs.out_rdata !== (tmo ? 32'h0 : e.rdata)) begin n_err++;
                $display("FAIL rnd_result[%0d]: got err=%b rdata=%h want %b/%h", t,
                         obs.out_err, obs.out_rdata, e.err | tmo, tmo ? 32'h0 : e.rdata); end
            n_vec++; if (obs.lat !== exp_lat) begin n_err++;
                $display("FAIL rnd_latency[%0d]: got %0d want %0d", t, obs.lat, exp_lat); end
            n_vec++; if (obs.req_unstable || obs.out_unstable || !obs.idle_after) begin
                n_err++;
                $display("FAIL rnd_stability[%0d]: got %b%b%b want 001", t,
                         obs.req_unstable, obs.out_unstable, obs.idle_after); end
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_stalls();
        test_timeout();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
